pll_lock_manager: RTL

- Supervises an ECP5 EHXPLLL instance (or any PLL with an active-high reset input and a lock output).
- Drives the PLL reset, waits for lock with a timeout and retry, and debounces lock for a stable period.
- Releases NUM_DOMAINS downstream resets in staggered order and re-runs the whole sequence on any loss of lock.
- Runs entirely in the free-running board reference clock domain. Downstream domains re-synchronise their reset locally.

---
 rtl/pll_lock_manager.sv | 136 +++++++++++++
 1 files changed

// File: rtl/pll_lock_manager.sv
// pll_lock_manager: PLL reset/lock supervisor with debounced lock and staggered domain reset release.
module pll_lock_manager #(
  parameter int NUM_DOMAINS      = 3,
  parameter int LOCK_SYNC_STAGES = 2,
  parameter int PLL_RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT     = 2500000,
  parameter int STABLE_CYCLES    = 1024,
  parameter int STAGGER_CYCLES   = 64,
  parameter int CNT_W            = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_lock,
  input  logic                   clear_status,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   all_ready,
  output logic                   lost_lock,
  output logic [CNT_W-1:0]       relock_count,
  output logic [CNT_W-1:0]       timeout_count
);
  localparam int MAX_AB = PLL_RST_CYCLES > LOCK_TIMEOUT ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD = STABLE_CYCLES > STAGGER_CYCLES ? STABLE_CYCLES : STAGGER_CYCLES;
  localparam int MAX_C  = MAX_AB > MAX_CD ? MAX_AB : MAX_CD;
  localparam int TW     = $clog2(MAX_C + 1);
  localparam logic [TW-1:0] RST_LAST = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] STG_LAST = TW'(STAGGER_CYCLES - 1);

  typedef enum logic [2:0] {S_PLL_RST, S_WAIT_LOCK, S_STABLE, S_RELEASE, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           cnt_q, cnt_d;
  logic [LOCK_SYNC_STAGES-1:0] sync_q;
  logic                    pll_rst_q, pll_rst_d;
  logic [NUM_DOMAINS-1:0]  domain_rst_q, domain_rst_d, dom_next;
  logic                    all_ready_q, all_ready_d;
  logic                    lost_lock_q, lost_lock_d;
  logic [CNT_W-1:0]        relock_count_q, relock_count_d;
  logic [CNT_W-1:0]        timeout_count_q, timeout_count_d;
  logic                    lock_s, start_rel, loss_ev, timeout_ev;

  assign lock_s = sync_q[LOCK_SYNC_STAGES-1];
  // Bits fall in index order, so the next one to release is always the lowest still set.
  assign dom_next = domain_rst_q & (domain_rst_q - NUM_DOMAINS'(1));

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    domain_rst_d = domain_rst_q;
    start_rel = 1'b0;
    loss_ev = 1'b0;
    timeout_ev = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        state_d = cnt_q == RST_LAST ? S_WAIT_LOCK : S_PLL_RST;
        cnt_d = cnt_q == RST_LAST ? '0 : cnt_q + TW'(1);
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d = TW'(1);
          start_rel = STABLE_CYCLES == 1;
        end else if (cnt_q == TO_LAST) begin
          timeout_ev = 1'b1;
          state_d = S_PLL_RST;
          cnt_d = '0;
        end else cnt_d = cnt_q + TW'(1);
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d = '0;
        end else if (cnt_q == STB_LAST) start_rel = 1'b1;
        else cnt_d = cnt_q + TW'(1);
      end
      S_RELEASE: begin
        if (!lock_s) loss_ev = 1'b1;
        else if (cnt_q == STG_LAST) begin
          domain_rst_d = dom_next;
          cnt_d = '0;
          state_d = dom_next == '0 ? S_RUN : S_RELEASE;
        end else cnt_d = cnt_q + TW'(1);
      end
      S_RUN: loss_ev = !lock_s;
      default: state_d = S_PLL_RST;
    endcase
    if (start_rel) begin
      state_d = NUM_DOMAINS == 1 ? S_RUN : S_RELEASE;
      cnt_d = '0;
      domain_rst_d = {NUM_DOMAINS{1'b1}} << 1;
    end
    if (loss_ev) begin
      state_d = S_PLL_RST;
      cnt_d = '0;
      domain_rst_d = '1;
    end
    pll_rst_d = state_d == S_PLL_RST;
    all_ready_d = state_d == S_RUN;
    lost_lock_d = clear_status ? 1'b0 : lost_lock_q | loss_ev;
    relock_count_d = clear_status ? '0 : relock_count_q + CNT_W'(loss_ev && relock_count_q != '1);
    timeout_count_d = clear_status ? '0 : timeout_count_q + CNT_W'(timeout_ev && timeout_count_q != '1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_PLL_RST;
      cnt_q <= '0;
      sync_q <= '0;
      pll_rst_q <= 1'b1;
      domain_rst_q <= '1;
      all_ready_q <= 1'b0;
      lost_lock_q <= 1'b0;
      relock_count_q <= '0;
      timeout_count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sync_q <= {sync_q[LOCK_SYNC_STAGES-2:0], pll_lock};
      pll_rst_q <= pll_rst_d;
      domain_rst_q <= domain_rst_d;
      all_ready_q <= all_ready_d;
      lost_lock_q <= lost_lock_d;
      relock_count_q <= relock_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign pll_rst = pll_rst_q;
  assign domain_rst = domain_rst_q;
  assign all_ready = all_ready_q;
  assign lost_lock = lost_lock_q;
  assign relock_count = relock_count_q;
  assign timeout_count = timeout_count_q;
endmodule
